// File: rtl/picorv32_mem_pkg.sv
// Shared types for the PicoRV32 native-bus initiator: FSM states, queued
// command record and the word-alignment helper.
package picorv32_mem_pkg;

   localparam int SIZE_OF_THE_BUS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic                       instr;
      logic [SIZE_OF_THE_BUS-1:0] addr;
      logic [SIZE_OF_THE_BUS-1:0] wdata;
      logic [3:0]                 wstrb;
   } mem_cmd_t;

   function automatic logic [SIZE_OF_THE_BUS-1:0] align_word(
      input logic [SIZE_OF_THE_BUS-1:0] a
   );
      return {a[SIZE_OF_THE_BUS-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/picorv32_mem_initiator_fifo.sv
// Synchronous command queue. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without an occupancy counter.
module mem_cmd_fifo
   import picorv32_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  mem_cmd_t din,
   output mem_cmd_t dout,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   mem_cmd_t       storage [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = storage[rd_ptr[AW-1:0]];

   // Entry storage; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (push && !full) storage[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer advance; simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/picorv32_mem_initiator.sv
// Drives queued commands one at a time onto the PicoRV32 native memory bus
// and returns one response per command, with a REQ-phase timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a queued command; pops and registers bus fields
// REQ     | mem_valid high, fields stable, waiting for mem_ready/timeout
// RESP    | rsp_valid high, fields stable until rsp_ready
module picorv32_mem_initiator
   import picorv32_mem_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_instr,
   input  logic [SIZE_OF_THE_BUS-1:0] cmd_addr,
   input  logic [SIZE_OF_THE_BUS-1:0] cmd_wdata,
   input  logic [3:0]                 cmd_wstrb,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [SIZE_OF_THE_BUS-1:0] rsp_rdata,
   output logic                       rsp_write,
   output logic                       rsp_error,
   output logic                       mem_valid,
   output logic                       mem_instr,
   input  logic                       mem_ready,
   output logic [SIZE_OF_THE_BUS-1:0] mem_addr,
   output logic [SIZE_OF_THE_BUS-1:0] mem_wdata,
   output logic [3:0]                 mem_wstrb,
   input  logic [SIZE_OF_THE_BUS-1:0] mem_rdata,
   output logic                       busy,
   output logic [15:0]                txn_count,
   output logic [7:0]                 err_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

   mem_state_t state;
   mem_cmd_t   cmd_in;
   mem_cmd_t   q_head;
   logic       q_full;
   logic       q_empty;
   logic       q_push;
   logic       q_pop;
   logic [TW-1:0] tmr;

   assign cmd_in    = '{instr: cmd_instr, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
   assign cmd_ready = !q_full;
   assign q_push    = cmd_valid && !q_full;
   assign q_pop     = (state == ST_IDLE) && !q_empty;
   assign busy      = (state != ST_IDLE) || !q_empty;

   mem_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (q_push),
      .pop   (q_pop),
      .din   (cmd_in),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Bus sequencing FSM; all bus and response outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         mem_valid <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_write <= 1'b0;
         rsp_error <= 1'b0;
         txn_count <= '0;
         err_count <= '0;
         tmr       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!q_empty) begin
                  mem_valid <= 1'b1;
                  mem_instr <= q_head.instr && (q_head.wstrb == 4'b0000);
                  mem_addr  <= align_word(q_head.addr);
                  mem_wdata <= (q_head.wstrb != 4'b0000) ? q_head.wdata : '0;
                  mem_wstrb <= q_head.wstrb;
                  tmr       <= TMR_LOAD;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A ready on the final counted cycle still wins over the timeout.
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= (mem_wstrb == 4'b0000) ? mem_rdata : '0;
                  rsp_write <= (mem_wstrb != 4'b0000);
                  rsp_error <= 1'b0;
                  txn_count <= txn_count + 16'd1;
                  state     <= ST_RESP;
               end else if (tmr == '0) begin
                  mem_valid <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_write <= (mem_wstrb != 4'b0000);
                  rsp_error <= 1'b1;
                  txn_count <= txn_count + 16'd1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state     <= ST_RESP;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_picorv32_mem_initiator.sv
// Directed bench for picorv32_mem_initiator: table of single transactions
// plus hand-written backpressure, timeout and mid-transaction reset cases.
module tb_picorv32_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_instr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [31:0] rsp_rdata;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy;
   logic [15:0] txn_count;
   logic [7:0]  err_count;

   logic        bp_mode;
   logic [31:0] rdata_drv;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_txn = 0;
   int exp_err = 0;

   always #5 clk = ~clk;

   assign mem_rdata = bp_mode ? (mem_addr ^ 32'h5A5A_0000) : rdata_drv;

   picorv32_mem_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_write(rsp_write), .rsp_error(rsp_error),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .busy(busy), .txn_count(txn_count), .err_count(err_count)
   );

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          delay;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic        e_instr;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic        e_write;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic push(input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
      int n;
      cmd_instr = instr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("push_wait", 80'(n < 50), 80'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      push(v.instr, v.addr, v.wdata, v.wstrb);
      n = 0;
      while (!mem_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk($sformatf("v%0d_latency", idx), 80'(n), 80'(1));
      chk($sformatf("v%0d_bus", idx), {mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata},
          {1'b1, v.e_instr, v.wstrb, v.e_addr, v.e_wdata});
      rdata_drv = v.rdata;
      for (int k = 0; k <= v.delay; k++) begin
         mem_ready = (k == v.delay);
         @(posedge clk); #1;
         if (k < v.delay)
            chk($sformatf("v%0d_stable%0d", idx, k),
                {mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata},
                {1'b1, v.e_instr, v.wstrb, v.e_addr, v.e_wdata});
      end
      mem_ready = 1'b0;
      rdata_drv = 32'hBAD0_BAD0;
      exp_txn++;
      chk($sformatf("v%0d_valid_drop", idx), 80'(mem_valid), 80'(0));
      chk($sformatf("v%0d_rsp", idx), {rsp_valid, rsp_error, rsp_write, rsp_rdata},
          {1'b1, 1'b0, v.e_write, v.e_rdata});
      chk($sformatf("v%0d_txn", idx), 80'(txn_count), 80'(exp_txn));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_hold", idx), {rsp_valid, rsp_write, rsp_rdata},
          {1'b1, v.e_write, v.e_rdata});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_done", idx), 80'(rsp_valid), 80'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic seen;
      // instr addr wdata wstrb delay rdata | e_addr e_instr e_wdata e_rdata e_write
      vecs[0] = '{1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0000_0013,
                  32'h0000_0104, 1'b1, 32'h0, 32'h0000_0013, 1'b0};
      vecs[1] = '{1'b0, 32'h0001_0002, 32'hDEAD_BEEF, 4'b0011, 1, 32'h1234_5678,
                  32'h0001_0000, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_2003, 32'hA5A5_A5A5, 4'b1111, 0, 32'h5555_5555,
                  32'h0000_2000, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b1};
      vecs[3] = '{1'b0, 32'h0000_0ABF, 32'h1111_1111, 4'b0000, 5, 32'hCAFE_F00D,
                  32'h0000_0ABC, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'b0000, 7, 32'h8000_0001,
                  32'hFFFF_FFFC, 1'b0, 32'h0, 32'h8000_0001, 1'b0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_instr = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; mem_ready = 1'b0;
      bp_mode = 1'b0; rdata_drv = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_bus", {mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata}, 80'(0));
      chk("reset_rsp", {rsp_valid, rsp_error, rsp_write, rsp_rdata}, 80'(0));
      chk("reset_misc", {busy, cmd_ready, txn_count, err_count}, {1'b0, 1'b1, 16'd0, 8'd0});
      reset = 1'b0;
      @(posedge clk); #1;

      // Backpressure: responder always ready, response side stalled.
      bp_mode = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++)
         push(i[0], 32'h101 + 32'(4 * i), 32'(i + 1), i[0] ? 4'b1111 : 4'b0000);
      chk("bp_full", 80'(cmd_ready), 80'(0));
      chk("bp_busy", 80'(busy), 80'(1));
      fork
         push(1'b1, 32'h101 + 32'(4 * 5), 32'd6, 4'b1111);
         begin
            rsp_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
               n = 0;
               while (!rsp_valid && n < 30) begin
                  @(posedge clk); #1; n++;
               end
               chk($sformatf("bp_rsp%0d", i), {rsp_valid, rsp_error, rsp_write, rsp_rdata},
                   {1'b1, 1'b0, i[0], i[0] ? 32'h0 : ((32'h100 + 32'(4 * i)) ^ 32'h5A5A_0000)});
               @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
         end
      join
      mem_ready = 1'b0; bp_mode = 1'b0;
      exp_txn += 6;
      @(posedge clk); #1;
      chk("bp_txn", 80'(txn_count), 80'(exp_txn));
      chk("bp_idle", {busy, rsp_valid, mem_valid}, 80'(0));

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Timeout: responder never acknowledges.
      push(1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      n = 0;
      while (!mem_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      n = 0;
      while (mem_valid && n < 40) begin
         n++; @(posedge clk); #1;
      end
      exp_txn++; exp_err++;
      chk("to_cycles", 80'(n), 80'(8));
      chk("to_rsp", {rsp_valid, rsp_error, rsp_write, rsp_rdata}, {1'b1, 1'b1, 1'b0, 32'h0});
      chk("to_counts", {txn_count, err_count}, {16'(exp_txn), 8'(exp_err)});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset while a request is outstanding and two more are queued.
      push(1'b0, 32'h0000_0500, 32'h0, 4'b0000);
      push(1'b0, 32'h0000_0504, 32'h0, 4'b0000);
      push(1'b0, 32'h0000_0508, 32'h0, 4'b0000);
      chk("rst_pre_req", {mem_valid, busy}, {1'b1, 1'b1});
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_txn = 0; exp_err = 0;
      chk("rst_after", {mem_valid, rsp_valid, busy, cmd_ready, txn_count, err_count},
          {1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'd0});
      mem_ready = 1'b1; rsp_ready = 1'b1; seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (mem_valid || rsp_valid) seen = 1'b1;
      end
      mem_ready = 1'b0; rsp_ready = 1'b0;
      chk("rst_discard", 80'(seen), 80'(0));
      run_vec(vecs[1], 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
